voice_sequencer: RTL and testbench

Frame scheduler for the time-shared `multi_voice` generator. On each `sample_tick_i` it snapshots the per-voice configuration. It then issues one start/ready transaction per enabled voice (0, 1, 2 in order) and captures each 10-bit result into a per-voice lane register. At frame end it pulses `frame_valid_o`, and flags overrun and timeout conditions.

---
 rtl/voice_seq_pkg.sv | 19 +
 rtl/voice_sequencer_if.sv | 22 ++
 rtl/voice_seq_timer.sv | 32 +++
 rtl/voice_sequencer.sv | 166 ++++++++++++++++
 tb/tb_voice_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_seq_pkg.sv
// Shared widths and FSM state encoding for the voice frame sequencer.
package voice_seq_pkg;
  localparam int NUM_VOICES = 3;
  localparam int FREQ_W     = 16;
  localparam int PW_W       = 12;
  localparam int SEL_W      = 4;
  localparam int WAVE_W     = 10;
  localparam int IDX_W      = 2;

  // IDLE wait tick | SELECT check enable | ISSUE start pulse | WAIT result/timeout | ADVANCE next voice | DONE frame_valid
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT,
    ST_ADVANCE,
    ST_DONE
  } seq_state_e;
endpackage

// File: rtl/voice_sequencer_if.sv
// Start/ready handshake and per-voice parameters towards the time-shared generator.
interface voice_sequencer_if;
  import voice_seq_pkg::*;

  logic              start_o;
  logic [IDX_W-1:0]  act_voice_o;
  logic [FREQ_W-1:0] freq_word_o;
  logic [PW_W-1:0]   pw_word_o;
  logic [SEL_W-1:0]  wave_sel_o;
  logic              ready_i;
  logic [WAVE_W-1:0] wave_i;

  modport master (
    output start_o, act_voice_o, freq_word_o, pw_word_o, wave_sel_o,
    input  ready_i, wave_i
  );

  modport slave (
    input  start_o, act_voice_o, freq_word_o, pw_word_o, wave_sel_o,
    output ready_i, wave_i
  );
endinterface

// File: rtl/voice_seq_timer.sv
// Clear/enable down-counter; expired_o flags the last allowed enabled cycle.
module voice_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == '0);
endmodule

// File: rtl/voice_sequencer.sv
// Per-frame scheduler issuing one generator transaction per enabled voice.
// Optional lane summer on mix_o is built only when VOICE_SEQ_MIX_EN is defined.
module voice_sequencer
  import voice_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sample_tick_i,
  input  logic                         clear_status_i,
  input  logic [NUM_VOICES-1:0]        voice_en_i,
  input  logic [NUM_VOICES*FREQ_W-1:0] freq_words_i,
  input  logic [NUM_VOICES*PW_W-1:0]   pw_words_i,
  input  logic [NUM_VOICES*SEL_W-1:0]  wave_sels_i,
  voice_sequencer_if.master            gen_if,
  output logic [NUM_VOICES*WAVE_W-1:0] waves_o,
  output logic                         frame_valid_o,
  output logic                         busy_o,
  output logic                         overrun_o,
  output logic                         timeout_o,
  output logic [WAVE_W+1:0]            mix_o
);
  // Counter expires on its zero count, so load one less to allow exactly TIMEOUT_CYCLES WAIT cycles.
  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_VOICES-1:0] en_snap_q;
  logic [FREQ_W-1:0] freq_snap_q [NUM_VOICES];
  logic [PW_W-1:0]   pw_snap_q   [NUM_VOICES];
  logic [SEL_W-1:0]  sel_snap_q  [NUM_VOICES];
  logic [WAVE_W-1:0] lane_q      [NUM_VOICES];
  logic              overrun_q, timeout_q;

  logic              snap_ld, lane_wr, timer_clr, timer_en, timer_exp;
  logic              timeout_set, overrun_set, start, frame_valid;
  logic [WAVE_W-1:0] lane_wdata;

  voice_seq_timer #(.CNT_W(8)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (timer_clr),
    .en_i       (timer_en),
    .load_val_i (TIMER_LOAD),
    .expired_o  (timer_exp)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_ld     = 1'b0;
    lane_wr     = 1'b0;
    lane_wdata  = '0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    timeout_set = 1'b0;
    start       = 1'b0;
    frame_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick_i) begin
          snap_ld = 1'b1;
          idx_d   = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (en_snap_q[idx_q]) begin
          state_d = ST_ISSUE;
        end else begin
          lane_wr = 1'b1;
          state_d = ST_ADVANCE;
        end
      end
      ST_ISSUE: begin
        start     = 1'b1;
        timer_clr = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (gen_if.ready_i) begin
          lane_wr    = 1'b1;
          lane_wdata = gen_if.wave_i;
          state_d    = ST_ADVANCE;
        end else if (timer_exp) begin
          timeout_set = 1'b1;
          lane_wr     = 1'b1;
          state_d     = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        frame_valid = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign overrun_set = sample_tick_i && (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      en_snap_q <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_snap_q[v] <= '0;
        pw_snap_q[v]   <= '0;
        sel_snap_q[v]  <= '0;
        lane_q[v]      <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (snap_ld) begin
        en_snap_q <= voice_en_i;
        for (int v = 0; v < NUM_VOICES; v++) begin
          freq_snap_q[v] <= freq_words_i[v*FREQ_W +: FREQ_W];
          pw_snap_q[v]   <= pw_words_i[v*PW_W +: PW_W];
          sel_snap_q[v]  <= wave_sels_i[v*SEL_W +: SEL_W];
        end
      end
      if (lane_wr) begin
        lane_q[idx_q] <= lane_wdata;
      end
      // Set has priority over a simultaneous clear.
      if (overrun_set)         overrun_q <= 1'b1;
      else if (clear_status_i) overrun_q <= 1'b0;
      if (timeout_set)         timeout_q <= 1'b1;
      else if (clear_status_i) timeout_q <= 1'b0;
    end
  end

  assign gen_if.start_o     = start;
  assign gen_if.act_voice_o = idx_q;
  assign gen_if.freq_word_o = freq_snap_q[idx_q];
  assign gen_if.pw_word_o   = pw_snap_q[idx_q];
  assign gen_if.wave_sel_o  = sel_snap_q[idx_q];

  assign frame_valid_o = frame_valid;
  assign busy_o        = (state_q != ST_IDLE);
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_lanes
    assign waves_o[v*WAVE_W +: WAVE_W] = lane_q[v];
  end

`ifdef VOICE_SEQ_MIX_EN
  assign mix_o = {2'b0, lane_q[0]} + {2'b0, lane_q[1]} + {2'b0, lane_q[2]};
`else
  assign mix_o = '0;
`endif
endmodule

// File: tb/tb_voice_sequencer.sv
// Scoreboard bench for voice_sequencer with a latency-configurable generator model.
`timescale 1ns/1ps
module tb_voice_sequencer;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sample_tick_i;
  logic        clear_status_i;
  logic [2:0]  voice_en_i;
  logic [47:0] freq_words_i;
  logic [35:0] pw_words_i;
  logic [11:0] wave_sels_i;
  logic [29:0] waves_o;
  logic        frame_valid_o, busy_o, overrun_o, timeout_o;
  logic [11:0] mix_o;

  voice_sequencer_if gen_if();

  voice_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_tick_i  (sample_tick_i),
    .clear_status_i (clear_status_i),
    .voice_en_i     (voice_en_i),
    .freq_words_i   (freq_words_i),
    .pw_words_i     (pw_words_i),
    .wave_sels_i    (wave_sels_i),
    .gen_if         (gen_if),
    .waves_o        (waves_o),
    .frame_valid_o  (frame_valid_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o),
    .mix_o          (mix_o)
  );

  always #10 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    int          voice;
    logic [15:0] freq;
    logic [11:0] pw;
    logic [3:0]  sel;
  } start_t;

  typedef struct {
    int          cyc;
    logic [29:0] waves;
    logic [11:0] mix;
  } frame_t;

  start_t sq[$];
  frame_t fq[$];

  function automatic logic [9:0] wave_fn(input logic [15:0] f, input logic [11:0] p,
                                         input logic [3:0] s, input int v);
    return f[15:6] + p[9:0] + {6'b0, s} + 10'(v);
  endfunction

  int          gen_lat    = 3;
  int          hang_voice = -1;
  bit          gen_pend   = 0;
  int          gen_due;
  int          gen_voice;
  logic [15:0] gen_freq;
  logic [11:0] gen_pw;
  logic [3:0]  gen_sel;

  // Generator model and output monitor, sampling on the falling edge.
  initial begin
    start_t s;
    frame_t f;
    gen_if.ready_i = 1'b0;
    gen_if.wave_i  = '0;
    forever begin
      @(negedge clk_i);
      gen_if.ready_i = 1'b0;
      if (rst_i) begin
        gen_pend = 0;
      end else begin
        if (gen_pend && cyc == gen_due) begin
          chk("stable_voice", gen_if.act_voice_o, gen_voice);
          chk("stable_freq", gen_if.freq_word_o, gen_freq);
          gen_if.ready_i = 1'b1;
          gen_if.wave_i  = wave_fn(gen_freq, gen_pw, gen_sel, gen_voice);
          gen_pend = 0;
        end
        if (gen_if.start_o) begin
          if (sq.size() == 0) begin
            chk("start_unexpected", gen_if.start_o, 0);
          end else begin
            s = sq.pop_front();
            chk("start_cycle", cyc, s.cyc);
            chk("start_voice", gen_if.act_voice_o, s.voice);
            chk("start_freq", gen_if.freq_word_o, s.freq);
            chk("start_pw", gen_if.pw_word_o, s.pw);
            chk("start_sel", gen_if.wave_sel_o, s.sel);
          end
          if (int'(gen_if.act_voice_o) != hang_voice) begin
            gen_pend  = 1;
            gen_due   = cyc + gen_lat;
            gen_voice = int'(gen_if.act_voice_o);
            gen_freq  = gen_if.freq_word_o;
            gen_pw    = gen_if.pw_word_o;
            gen_sel   = gen_if.wave_sel_o;
          end
        end
        if (frame_valid_o) begin
          if (fq.size() == 0) begin
            chk("frame_unexpected", frame_valid_o, 0);
          end else begin
            f = fq.pop_front();
            chk("frame_cycle", cyc, f.cyc);
            chk("frame_waves", waves_o, f.waves);
            chk("frame_mix", mix_o, f.mix);
          end
        end
      end
    end
  end

  task automatic run_frame(input logic [2:0] en, input int lat, input int hang, output int t0);
    int          s;
    frame_t      f;
    start_t      st;
    logic [15:0] fw;
    logic [11:0] pw;
    logic [3:0]  sl;
    voice_en_i = en;
    gen_lat    = lat;
    hang_voice = hang;
    t0 = cyc;
    s  = t0 + 1;
    f.waves = '0;
    for (int v = 0; v < 3; v++) begin
      fw = freq_words_i[16*v +: 16];
      pw = pw_words_i[12*v +: 12];
      sl = wave_sels_i[4*v +: 4];
      if (en[v]) begin
        st.cyc = s + 1; st.voice = v; st.freq = fw; st.pw = pw; st.sel = sl;
        sq.push_back(st);
        if (v == hang) begin
          s += TO + 3;
        end else begin
          f.waves[10*v +: 10] = wave_fn(fw, pw, sl, v);
          s += lat + 3;
        end
      end else begin
        s += 2;
      end
    end
    f.cyc = s;
`ifdef VOICE_SEQ_MIX_EN
    f.mix = {2'b0, f.waves[9:0]} + {2'b0, f.waves[19:10]} + {2'b0, f.waves[29:20]};
`else
    f.mix = '0;
`endif
    fq.push_back(f);
    sample_tick_i = 1'b1;
    @(negedge clk_i);
    sample_tick_i = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy_o && i < 400) begin
      @(negedge clk_i);
      i++;
    end
    chk("frame_end_busy", busy_o, 0);
    chk("frames_pending", fq.size(), 0);
    chk("starts_pending", sq.size(), 0);
    @(negedge clk_i);
  endtask

  task automatic pulse_clear();
    clear_status_i = 1'b1;
    @(negedge clk_i);
    clear_status_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_start"}, gen_if.start_o, 0);
    chk({tag, "_fvalid"}, frame_valid_o, 0);
    chk({tag, "_waves"}, waves_o, 0);
    chk({tag, "_voice"}, gen_if.act_voice_o, 0);
    chk({tag, "_freq"}, gen_if.freq_word_o, 0);
    chk({tag, "_pw"}, gen_if.pw_word_o, 0);
    chk({tag, "_sel"}, gen_if.wave_sel_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
    chk({tag, "_mix"}, mix_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_i          = 1'b1;
    sample_tick_i  = 1'b0;
    clear_status_i = 1'b0;
    voice_en_i     = '0;
    freq_words_i   = {16'h0400, 16'h0200, 16'h0100};
    pw_words_i     = {12'h300, 12'h200, 12'h100};
    wave_sels_i    = 12'h222;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("reset");

    // All voices, L=3: frame at T+19.
    run_frame(3'b111, 3, -1, t0);
    wait_idle();
    chk("full_timeout", timeout_o, 0);
    chk("full_overrun", overrun_o, 0);

    // Voice 1 disabled, its stale lane must be cleared.
    run_frame(3'b101, 3, -1, t0);
    wait_idle();

    // No voices enabled.
    freq_words_i = {16'h1234, 16'hBEEF, 16'h0F0F};
    run_frame(3'b000, 3, -1, t0);
    wait_idle();

    // Voice 1 never answers: timeout, lane1 cleared, frame at T+32.
    wave_sels_i = 12'h421;
    run_frame(3'b111, 3, 1, t0);
    wait_idle();
    chk("timeout_set", timeout_o, 1);
    pulse_clear();
    chk("timeout_cleared", timeout_o, 0);

    // Ready in the very cycle the timer expires: ready wins, no flag.
    run_frame(3'b111, TO, -1, t0);
    wait_idle();
    chk("edge_timeout_flag", timeout_o, 0);

    // Overrun: tick+clear at T+5 and tick in DONE; only one frame.
    run_frame(3'b111, 3, -1, t0);
    wait_until(t0 + 5);
    sample_tick_i  = 1'b1;
    clear_status_i = 1'b1;
    @(negedge clk_i);
    sample_tick_i  = 1'b0;
    clear_status_i = 1'b0;
    chk("overrun_set_wins", overrun_o, 1);
    wait_until(t0 + 19);
    chk("done_cycle_fvalid", frame_valid_o, 1);
    sample_tick_i = 1'b1;
    @(negedge clk_i);
    sample_tick_i = 1'b0;
    wait_idle();
    chk("overrun_sticky", overrun_o, 1);
    pulse_clear();
    chk("overrun_cleared", overrun_o, 0);

    // Config change mid-frame must not reach the generator.
    freq_words_i = {16'h0400, 16'h0200, 16'h0100};
    run_frame(3'b111, 3, -1, t0);
    wait_until(t0 + 3);
    freq_words_i = {16'hAAAA, 16'hBBBB, 16'hCCCC};
    pw_words_i   = {12'h0FF, 12'h0EE, 12'h0DD};
    wait_idle();

    // Reset mid-frame at T+9.
    freq_words_i = {16'h0800, 16'h0440, 16'h0220};
    pw_words_i   = {12'h123, 12'h045, 12'h067};
    run_frame(3'b111, 3, -1, t0);
    wait_until(t0 + 9);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("midrst");
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_starts_left", sq.size(), 1);
    sq.delete();
    fq.delete();
    repeat (30) @(negedge clk_i);
    chk("midrst_idle", busy_o, 0);

    // Fresh frame after reset starts at voice 0.
    run_frame(3'b111, 3, -1, t0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
